// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA timing generator in the pixel-clock domain.
// Synchronizes the PLL lock, runs the raster counters only while locked and
// registers sync/blanking/coordinate/strobe outputs for the same pixel.
// Optional colour-bar source is enabled by defining VGA_TEST_PATTERN_EN;
// without it pix_r/g/b are tied to zero.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       line_start,
   output logic       frame_start,
   output logic       running,
   output logic [7:0] pix_r,
   output logic [7:0] pix_g,
   output logic [7:0] pix_b
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // All raster constants pre-sized to the 10-bit counter width.
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t     state_reg, state_next;
   logic       locked_meta_reg;
   logic       locked_s;
   logic [9:0] h_cnt_reg, v_cnt_reg;
   logic       active, hs_on, vs_on;

   // Two-flop synchronizer bringing the asynchronous PLL lock into clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         locked_meta_reg <= 1'b0;
         locked_s        <= 1'b0;
      end else begin
         locked_meta_reg <= pll_locked;
         locked_s        <= locked_meta_reg;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // FSM next state: run exactly while the synchronized lock is high.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (locked_s)  state_next = RUN;
         RUN:     if (!locked_s) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Raster counters advance only while staying in RUN; any other case
   // (idle, or the edge that leaves RUN) parks them at pixel (0,0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else if (state_reg == RUN && locked_s) begin
         if (h_cnt_reg == H_LAST) begin
            h_cnt_reg <= '0;
            if (v_cnt_reg == V_LAST) v_cnt_reg <= '0;
            else                     v_cnt_reg <= v_cnt_reg + 10'd1;
         end else begin
            h_cnt_reg <= h_cnt_reg + 10'd1;
         end
      end else begin
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end
   end

   assign active = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
   assign hs_on  = (h_cnt_reg >= HS_FIRST) && (h_cnt_reg <= HS_LAST);
   assign vs_on  = (v_cnt_reg >= VS_FIRST) && (v_cnt_reg <= VS_LAST);

   // Output stage: decode of the current counter value, one register late.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         running     <= 1'b0;
      end else if (state_reg == RUN) begin
         hsync       <= ~hs_on;
         vsync       <= ~vs_on;
         de          <= active;
         x           <= active ? h_cnt_reg : 10'd0;
         y           <= active ? v_cnt_reg : 10'd0;
         line_start  <= (h_cnt_reg == 10'd0);
         frame_start <= (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
         running     <= 1'b1;
      end else begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         running     <= 1'b0;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;

   logic [6:0] bar_ge;
   logic [2:0] bar_idx;

   // One comparator per bar boundary; the bar index is how many are passed.
   for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
      assign bar_ge[gi-1] = (h_cnt_reg >= 10'(BAR_W * gi));
   end

   // Population count of passed boundaries gives the bar number 0..7.
   always_comb begin
      bar_idx = 3'd0;
      for (int i = 0; i < 7; i++) bar_idx = bar_idx + {2'b00, bar_ge[i]};
   end

   // Colour bars in the same stage as de: bit0 clears blue, bit1 red, bit2 green.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_r <= '0;
         pix_g <= '0;
         pix_b <= '0;
      end else if (state_reg == RUN && active) begin
         pix_r <= {8{~bar_idx[1]}};
         pix_g <= {8{~bar_idx[2]}};
         pix_b <= {8{~bar_idx[0]}};
      end else begin
         pix_r <= '0;
         pix_g <= '0;
         pix_b <= '0;
      end
   end
`else
   assign pix_r = 8'h00;
   assign pix_g = 8'h00;
   assign pix_b = 8'h00;
`endif

endmodule
